// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: shadow scoreboard, DIV occupancy sequencing, stall/flush and forwarding.
// Optional HAZARD_PERF_EN adds stall/flush cycle counters (perf_stall, perf_flush).
module hazard_ctl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic [4:0] id_rd,
    input  logic       id_wreg,
    input  logic       id_rmem,
    input  logic       id_div,
    input  logic       ex_br_taken,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_if,
    output logic       flush_id,
    output logic       bubble_mem,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       div_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    // state  | meaning
    // IDLE   | normal flow; a DIV just entered EX is its first occupancy cycle
    // DIVRUN | DIV held in EX; counter == 1 marks the cycle it leaves for MEM
    typedef enum logic {IDLE, DIVRUN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       ex_wreg, ex_rmem, ex_div, ex_use1, ex_use2;
    logic       mem_wreg, wb_wreg;

    logic div_stall, div_last, br_flush, load_use, id_load;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        bubble_mem = 1'b0;

        // The cycle a DIV first sits in EX already counts as occupancy, so it stalls from IDLE.
        div_last  = (state == DIVRUN) && (cnt == CNT_W'(1));
        div_stall = ((state == DIVRUN) && !div_last) || ((state == IDLE) && ex_div);
        div_busy  = div_stall || div_last;
        br_flush  = ex_br_taken && !div_busy;
        load_use  = ex_rmem && ex_wreg && id_valid && !div_busy && !ex_br_taken &&
                    ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

        if (div_stall) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
        end else if (br_flush) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_id = 1'b1;
        end

        case (state)
            IDLE: begin
                if (ex_div) begin
                    state_nx = DIVRUN;
                    cnt_nx   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            DIVRUN: begin
                cnt_nx = cnt - CNT_W'(1);
                if (div_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign id_load = id_valid && !flush_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_wreg  <= 1'b0;
            ex_rmem  <= 1'b0;
            ex_div   <= 1'b0;
            ex_use1  <= 1'b0;
            ex_use2  <= 1'b0;
            mem_rd   <= '0;
            mem_wreg <= 1'b0;
            wb_rd    <= '0;
            wb_wreg  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            wb_rd   <= mem_rd;
            wb_wreg <= mem_wreg;
            if (div_stall) begin
                mem_rd   <= '0;
                mem_wreg <= 1'b0;
            end else begin
                mem_rd   <= ex_rd;
                mem_wreg <= ex_wreg;
                ex_rd    <= id_load ? id_rd : 5'd0;
                ex_rs1   <= id_load ? id_rs1 : 5'd0;
                ex_rs2   <= id_load ? id_rs2 : 5'd0;
                ex_wreg  <= id_load && id_wreg && (id_rd != 5'd0);
                ex_rmem  <= id_load && id_rmem;
                ex_div   <= id_load && id_div;
                ex_use1  <= id_load && id_use1;
                ex_use2  <= id_load && id_use2;
            end
        end
    end

    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (ex_use1 && mem_wreg && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
            fwd_a = 2'd1;
        else if (ex_use1 && wb_wreg && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
            fwd_a = 2'd2;
        if (ex_use2 && mem_wreg && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
            fwd_b = 2'd1;
        else if (ex_use2 && wb_wreg && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
            fwd_b = 2'd2;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            perf_stall <= perf_stall + 32'(stall_if);
            perf_flush <= perf_flush + 32'(flush_if);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed self-checking bench for hazard_ctl with DIV_CYCLES = 4.
module tb_hazard_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use1, id_use2, id_wreg, id_rmem, id_div, ex_br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_if, stall_id, stall_ex, flush_if, flush_id, bubble_mem, div_busy;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    // {stall_if, stall_id, stall_ex, flush_if, flush_id, bubble_mem, div_busy}
    logic [6:0] ctl;
    assign ctl = {stall_if, stall_id, stall_ex, flush_if, flush_id, bubble_mem, div_busy};

    hazard_ctl #(.DIV_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
        .id_wreg(id_wreg), .id_rmem(id_rmem), .id_div(id_div),
        .ex_br_taken(ex_br_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if(flush_if), .flush_id(flush_id), .bubble_mem(bubble_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .div_busy(div_busy)
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic w, input logic m, input logic d);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
        id_rd = rd; id_wreg = w; id_rmem = m; id_div = d;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_br_taken = 1'b0;
        nop();
        tick();
        settle();
        check_val("rst_ctl", 32'(ctl), 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check_val("rst_ctl_rel", 32'(ctl), 32'h0);
        check_val("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);

        // load-use: lw x5 then add x6,x5,x7
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        check_val("lu_stall", 32'(ctl), 32'b1100100);
        tick();
        settle();
        check_val("lu_release", 32'(ctl), 32'h0);
        tick();
        nop();
        settle();
        check_val("lu_fwd_a", 32'(fwd_a), 32'd2);
        check_val("lu_fwd_b", 32'(fwd_b), 32'd0);

        // branch with a pending load-use: flush wins, no stall
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        ex_br_taken = 1'b1;
        settle();
        check_val("br_flush", 32'(ctl), 32'b0001100);
        tick();
        ex_br_taken = 1'b0;
        settle();
        check_val("br_after", 32'(ctl), 32'h0);
`ifdef HAZARD_PERF_EN
        check_val("perf_stall", perf_stall, 32'd1);
        check_val("perf_flush", perf_flush, 32'd1);
`endif
        nop();
        tick(); tick(); tick();

        // back-to-back ALU: add x3 ; sub x4,x3,x3
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        settle();
        check_val("alu_nostall", 32'(ctl), 32'h0);
        tick();
        nop();
        settle();
        check_val("alu_fwd", 32'({fwd_a, fwd_b}), 32'b0101);

        // rd = x0: nothing forwards
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        settle();
        check_val("x0_fwd", 32'({fwd_a, fwd_b}), 32'h0);

        // MEM beats WB for the same rd; unused operand never forwards
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        settle();
        check_val("mem_prio_a", 32'(fwd_a), 32'd1);
        check_val("nouse_b", 32'(fwd_b), 32'd0);
        tick(); tick(); tick();

        // DIV x8, 4 cycles; follower add x12,x8 must stay in ID
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        settle();
        check_val("div_c1", 32'(ctl), 32'b1110011);
        tick();
        ex_br_taken = 1'b1;
        settle();
        check_val("div_c2_br_ign", 32'(ctl), 32'b1110011);
        tick();
        ex_br_taken = 1'b0;
        settle();
        check_val("div_c3", 32'(ctl), 32'b1110011);
        tick();
        settle();
        check_val("div_c4", 32'(ctl), 32'b0000001);
        tick();
        nop();
        settle();
        check_val("div_done", 32'(ctl), 32'h0);
        check_val("div_fwd_a", 32'(fwd_a), 32'd1);
        tick(); tick(); tick();

        // rst during DIVRUN cycle 2 aborts the sequence
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        nop();
        tick();
        settle();
        check_val("div_rst_pre", 32'(div_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_val("div_rst_busy", 32'(div_busy), 32'd0);
        check_val("div_rst_ctl", 32'(ctl), 32'h0);
        tick();
        settle();
        check_val("div_rst_stay", 32'(ctl), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
